// File: rtl/seq_div_pkg.sv
// Shared types and sizing helpers for the sequential restoring divider.
package seq_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_e;

  // Step counter width: it must hold M-1 (it counts M-1 down to 0).
  function automatic int cnt_width(input int m);
    return (m > 2) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract, keep or restore.
module div_step #(
  parameter int N = 4
) (
  input  logic [N-1:0] r_i,
  input  logic         d_msb_i,
  input  logic [N-1:0] divisor_i,
  output logic [N-1:0] r_o,
  output logic         q_bit_o
);

  logic [N:0] r_shift;
  logic [N:0] diff;

  // The incoming remainder is always below the divisor, so its N+1-bit form has a zero MSB
  // and only the low N bits need to be carried between iterations.
  // NOTE: always_comb assigns every output on every path, so no latch can be inferred.
  always_comb begin
    r_shift = {r_i, d_msb_i};
    diff    = r_shift - {1'b0, divisor_i};
    q_bit_o = ~diff[N];
    r_o     = diff[N] ? r_shift[N-1:0] : diff[N-1:0];
  end

endmodule

// File: rtl/seq_restoring_divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock, M+1 cycle latency.
module seq_restoring_divider
  import seq_div_pkg::*;
#(
  parameter int M = 8,
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [M-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [M-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero
);

  localparam int            CW   = cnt_width(M);
  localparam logic [CW-1:0] LAST = CW'(M - 1);

  state_e        state_q, state_d;
  logic [N-1:0]  r_q, r_d;
  logic [N-1:0]  dvs_q, dvs_d;
  logic [M-1:0]  d_q, d_d;
  logic [M-1:0]  qs_q, qs_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [M-1:0]  quot_q, quot_d;
  logic [N-1:0]  rem_q, rem_d;
  logic          dbz_q, dbz_d;
  logic          busy_q, done_q;

  logic [N-1:0]  step_r;
  logic          step_bit;

  div_step #(.N(N)) u_step (
    .r_i      (r_q),
    .d_msb_i  (d_q[M-1]),
    .divisor_i(dvs_q),
    .r_o      (step_r),
    .q_bit_o  (step_bit)
  );

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    dvs_d   = dvs_q;
    d_d     = d_q;
    qs_d    = qs_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;

    unique case (state_q)
      IDLE, FIN: begin
        state_d = IDLE;
        if (start) begin
          if (divisor != '0) begin
            state_d = RUN;
            r_d     = '0;
            dvs_d   = divisor;
            d_d     = dividend;
            qs_d    = '0;
            cnt_d   = LAST;
          end else begin
            // Zero divisor bypasses iteration and reports saturated quotient.
            state_d = FIN;
            quot_d  = '1;
            rem_d   = '0;
            dbz_d   = 1'b1;
          end
        end
      end
      RUN: begin
        r_d   = step_r;
        d_d   = {d_q[M-2:0], 1'b0};
        qs_d  = {qs_q[M-2:0], step_bit};
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          state_d = FIN;
          quot_d  = {qs_q[M-2:0], step_bit};
          rem_d   = step_r;
          dbz_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      r_q     <= '0;
      dvs_q   <= '0;
      d_q     <= '0;
      qs_q    <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      dvs_q   <= dvs_d;
      d_q     <= d_d;
      qs_q    <= qs_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
      busy_q  <= (state_d == RUN);
      done_q  <= (state_d == FIN);
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Self-checking bench: directed table, multi-cycle corner sequences, exhaustive 8/4 and random 16/8 sweeps.
module tb_seq_restoring_divider;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        start8 = 1'b0;
  logic [7:0]  dividend8 = '0;
  logic [3:0]  divisor8 = '0;
  logic        busy8, done8, z8;
  logic [7:0]  q8;
  logic [3:0]  r8;

  logic        start16 = 1'b0;
  logic [15:0] dividend16 = '0;
  logic [7:0]  divisor16 = '0;
  logic        busy16, done16, z16;
  logic [15:0] q16;
  logic [7:0]  r16;

  seq_restoring_divider #(.M(8), .N(4)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .dividend(dividend8), .divisor(divisor8),
    .busy(busy8), .done(done8), .quotient(q8), .remainder(r8), .div_by_zero(z8)
  );

  seq_restoring_divider #(.M(16), .N(8)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .dividend(dividend16), .divisor(divisor16),
    .busy(busy16), .done(done16), .quotient(q16), .remainder(r16), .div_by_zero(z16)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: plain integer division; zero divisor saturates the quotient.
  task automatic ref_div(input int unsigned a, input int unsigned b, input int mw,
                         output int unsigned q, output int unsigned r, output int unsigned z);
    if (b == 0) begin
      q = (32'd1 << mw) - 1; r = 0; z = 1;
    end else begin
      q = a / b; r = a % b; z = 0;
    end
  endtask

  // Accept on the next edge; lat counts cycles after the accept edge up to and including done.
  task automatic run8(input logic [7:0] a, input logic [3:0] b,
                      output int lat, output int busy_cnt, output int overlap);
    @(negedge clk);
    dividend8 = a; divisor8 = b; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    lat = 1; busy_cnt = 0; overlap = 0;
    while (!done8 && lat < 40) begin
      if (busy8) busy_cnt++;
      @(posedge clk); #1;
      lat++;
    end
    if (busy8 && done8) overlap++;
  endtask

  task automatic run16(input logic [15:0] a, input logic [7:0] b, output int lat);
    @(negedge clk);
    dividend16 = a; divisor16 = b; start16 = 1'b1;
    @(posedge clk); #1;
    start16 = 1'b0;
    lat = 1;
    while (!done16 && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic wait_done8(output int lat);
    lat = 1;
    while (!done8 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic count_dones8(input int cycles, output int dones);
    dones = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (done8) dones++;
    end
  endtask

  typedef struct {
    logic [7:0] a;
    logic [3:0] b;
    logic [7:0] q;
    logic [3:0] r;
    logic       z;
    int         lat;
    int         busy_cycles;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int lat, bc, ov, dn;
    int unsigned eq, er, ez, prod;

    tbl[0] = '{8'd200, 4'd7,  8'd28,  4'd4, 1'b0, 9, 8};
    tbl[1] = '{8'd255, 4'd15, 8'd17,  4'd0, 1'b0, 9, 8};
    tbl[2] = '{8'd5,   4'd9,  8'd0,   4'd5, 1'b0, 9, 8};
    tbl[3] = '{8'd0,   4'd3,  8'd0,   4'd0, 1'b0, 9, 8};
    tbl[4] = '{8'd100, 4'd0,  8'd255, 4'd0, 1'b1, 1, 0};
    tbl[5] = '{8'd255, 4'd1,  8'd255, 4'd0, 1'b0, 9, 8};
    tbl[6] = '{8'd7,   4'd7,  8'd1,   4'd0, 1'b0, 9, 8};
    tbl[7] = '{8'd254, 4'd15, 8'd16,  4'd14, 1'b0, 9, 8};

    // Reset state
    #12;
    check("reset busy", busy8, 0);
    check("reset done", done8, 0);
    check("reset quotient", q8, 0);
    check("reset remainder", r8, 0);
    check("reset dbz", z8, 0);
    @(negedge clk);
    rst = 1'b0;

    // Directed table
    foreach (tbl[i]) begin
      run8(tbl[i].a, tbl[i].b, lat, bc, ov);
      check($sformatf("tbl%0d quotient", i), q8, tbl[i].q);
      check($sformatf("tbl%0d remainder", i), r8, tbl[i].r);
      check($sformatf("tbl%0d dbz", i), z8, tbl[i].z);
      check($sformatf("tbl%0d latency", i), lat, tbl[i].lat);
      check($sformatf("tbl%0d busy cycles", i), bc, tbl[i].busy_cycles);
      check($sformatf("tbl%0d busy&done", i), ov, 0);
    end

    // Start pulsed mid-RUN with other operands must be ignored
    count_dones8(2, dn);
    @(negedge clk);
    dividend8 = 8'd200; divisor8 = 4'd7; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    dividend8 = 8'd99; divisor8 = 4'd3; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0; dividend8 = 8'd0; divisor8 = 4'd0;
    lat = 5;
    while (!done8 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("midrun latency", lat, 9);
    check("midrun quotient", q8, 28);
    check("midrun remainder", r8, 4);
    count_dones8(12, dn);
    check("midrun no extra done", dn, 0);

    // Start asserted in the FIN cycle is accepted back-to-back
    run8(8'd200, 8'd7, lat, bc, ov);
    check("b2b first quotient", q8, 28);
    dividend8 = 8'd255; divisor8 = 4'd15; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    check("b2b accepted busy", busy8, 1);
    check("b2b hold quotient at accept", q8, 28);
    check("b2b hold remainder at accept", r8, 4);
    wait_done8(lat);
    check("b2b second latency", lat, 9);
    check("b2b second quotient", q8, 17);
    check("b2b second remainder", r8, 0);

    // Asynchronous reset mid-RUN clears everything and suppresses done
    run8(8'd100, 4'd0, lat, bc, ov);
    check("pre-reset dbz", z8, 1);
    @(negedge clk);
    dividend8 = 8'd200; divisor8 = 4'd7; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("async rst busy", busy8, 0);
    check("async rst done", done8, 0);
    check("async rst quotient", q8, 0);
    check("async rst remainder", r8, 0);
    check("async rst dbz", z8, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    count_dones8(12, dn);
    check("no done after abort", dn, 0);
    run8(8'd200, 4'd7, lat, bc, ov);
    check("post-reset quotient", q8, 28);
    check("post-reset remainder", r8, 4);
    check("post-reset latency", lat, 9);

    // Exhaustive sweep, M=8 N=4
    for (int a = 0; a < 256; a++) begin
      for (int b = 0; b < 16; b++) begin
        run8(8'(a), 4'(b), lat, bc, ov);
        ref_div(a, b, 8, eq, er, ez);
        check($sformatf("sweep %0d/%0d", a, b), {q8, r8, z8}, {eq[7:0], er[3:0], ez[0]});
        if (b != 0) begin
          prod = int'(q8) * b + int'(r8);
          check($sformatf("sweep %0d/%0d q*d+r", a, b), prod, a);
          check($sformatf("sweep %0d/%0d r<d", a, b), (int'(r8) < b), 1);
        end
      end
    end

    // Random, M=16 N=8
    for (int k = 0; k < 300; k++) begin
      logic [15:0] ra;
      logic [7:0]  rb;
      ra = 16'($urandom);
      rb = (k % 25 == 0) ? 8'd0 : 8'($urandom);
      run16(ra, rb, lat);
      ref_div(ra, rb, 16, eq, er, ez);
      check($sformatf("rand16 %0d/%0d", ra, rb), {q16, r16, z16}, {eq[15:0], er[7:0], ez[0]});
      check($sformatf("rand16 %0d/%0d latency", ra, rb), lat, (rb == 0) ? 1 : 17);
      if (rb != 0) begin
        prod = int'(q16) * rb + int'(r16);
        check($sformatf("rand16 %0d/%0d q*d+r", ra, rb), prod, ra);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
